// File: rtl/hex_display_mux.sv
// Multiplexed 7-segment hex display driver with shadow load, blanking and leading-zero suppression.
// Optional macro HEX_DISPLAY_MUX_BRIGHTNESS_EN adds a 4-bit brightness (duty) input.
module hex_display_mux #(
    parameter int DIGITS         = 4,
    parameter int DIV_BITS       = 18,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   in_val,
    input  logic [DIGITS-1:0]     in_dot,
    input  logic [DIGITS-1:0]     in_blank,
    input  logic                  load,
    input  logic                  lzb_en,
`ifdef HEX_DISPLAY_MUX_BRIGHTNESS_EN
    input  logic [3:0]            brightness,
`endif
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_DARK = {7{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_IDLE  = {DIGITS{AN_ACTIVE_LOW}};

    logic [DIV_BITS-1:0] divider;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] shadow_val;
    logic [DIGITS-1:0]   shadow_dot;
    logic [DIGITS-1:0]   shadow_blank;

    logic [3:0]          cur_nib;
    logic                cur_dot;
    logic                cur_blank;
    logic                lead_zero;
    logic                dark;
    logic [DIGITS-1:0]   an_act;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    always_comb begin
        cur_nib   = '0;
        cur_dot   = 1'b0;
        cur_blank = 1'b0;
        lead_zero = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib   = shadow_val[4*i +: 4];
                cur_dot   = shadow_dot[i];
                cur_blank = shadow_blank[i];
                // this digit and every more-significant one are zero
                lead_zero = ((shadow_val >> (4*i)) == '0);
            end
        end
        dark = cur_blank | (lzb_en & (idx != '0) & lead_zero);
`ifdef HEX_DISPLAY_MUX_BRIGHTNESS_EN
        if (divider[DIV_BITS-1 -: 4] > brightness) dark = 1'b1;
`endif
        an_act = '0;
        for (int i = 0; i < DIGITS; i++) begin
            an_act[i] = (idx == IDX_W'(i)) & ~dark;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            divider      <= '0;
            idx          <= '0;
            shadow_val   <= '0;
            shadow_dot   <= '0;
            shadow_blank <= '0;
            an           <= AN_IDLE;
            seg          <= SEG_DARK;
            dp           <= SEG_ACTIVE_LOW;
            frame_done   <= 1'b0;
        end else begin
            divider <= divider + 1'b1;
            if (&divider) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            frame_done <= (&divider) & (idx == LAST_IDX);
            if (load) begin
                shadow_val   <= in_val;
                shadow_dot   <= in_dot;
                shadow_blank <= in_blank;
            end
            // pins reflect the pre-edge slot and shadow, polarity folded in by XOR
            an  <= an_act ^ AN_IDLE;
            seg <= (dark ? 7'h00 : glyph(cur_nib)) ^ SEG_DARK;
            dp  <= (~dark & cur_dot) ^ SEG_ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_hex_display_mux.sv
// Randomised bench for hex_display_mux (DIGITS=4, DIV_BITS=4, active-low pins) against a cycle-count model.
module tb_hex_display_mux;

    localparam int DIGITS   = 4;
    localparam int DIV_BITS = 4;
    localparam int SLOT     = 1 << DIV_BITS;
    localparam int FRAME    = SLOT * DIGITS;
    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_val;
    logic [3:0]  in_dot;
    logic [3:0]  in_blank;
    logic        load;
    logic        lzb_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    always #5 clk = ~clk;

    hex_display_mux #(
        .DIGITS(DIGITS), .DIV_BITS(DIV_BITS), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .in_val(in_val), .in_dot(in_dot), .in_blank(in_blank),
        .load(load), .lzb_en(lzb_en),
`ifdef HEX_DISPLAY_MUX_BRIGHTNESS_EN
        .brightness(4'hF),
`endif
        .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    int checks = 0;
    int errors = 0;

    // model: cycles since reset plus the shadow contents
    int          n;
    logic [15:0] m_val;
    logic [3:0]  m_dot;
    logic [3:0]  m_blank;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, wanted %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_fd;
        logic       dark;
        logic [3:0] nib;
        int         ix;
        if (rst) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
        end else begin
            ix   = (n / SLOT) % DIGITS;
            nib  = 4'((m_val >> (4*ix)) & 16'hF);
            dark = m_blank[ix] || (lzb_en && ix != 0 && (m_val >> (4*ix)) == 16'h0);
            e_an  = dark ? 4'hF : ~(4'b0001 << ix);
            e_seg = dark ? 7'h7F : ~GLYPH[nib];
            e_dp  = dark ? 1'b1 : ~m_dot[ix];
            e_fd  = ((n + 1) % FRAME) == 0;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            n = 0; m_val = '0; m_dot = '0; m_blank = '0;
        end else begin
            if (load) begin
                m_val = in_val; m_dot = in_dot; m_blank = in_blank;
            end
            n++;
        end
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        in_val = v; in_dot = d; in_blank = b; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        n = 0; m_val = '0; m_dot = '0; m_blank = '0;
        rst = 1'b1; load = 1'b0; lzb_en = 1'b0;
        in_val = '0; in_dot = '0; in_blank = '0;
        repeat (3) tick();
        rst = 1'b0;

        do_load(16'h12AF, 4'b0000, 4'b0000);
        repeat (2 * FRAME + 2) tick();

        lzb_en = 1'b1;
        do_load(16'h0050, 4'b0000, 4'b0000);
        repeat (FRAME) tick();
        lzb_en = 1'b0;
        repeat (FRAME) tick();

        lzb_en = 1'b1;
        do_load(16'h0000, 4'b0000, 4'b0000);
        repeat (FRAME) tick();
        lzb_en = 1'b0;

        do_load(16'h1234, 4'b0001, 4'b0100);
        repeat (FRAME) tick();

        in_val = 16'hBEEF; in_dot = 4'b1010; in_blank = 4'b0000;
        repeat (FRAME) tick();
        do_load(16'hBEEF, 4'b1010, 4'b0000);
        repeat (FRAME) tick();

        // load on the very edge where the scan wraps 3 -> 0
        repeat (FRAME) begin
            if ((n % FRAME) != FRAME - 1) tick();
        end
        do_load(16'hC0DE, 4'b0100, 4'b0000);
        repeat (FRAME) tick();

        // reset mid-scan while digit 2 is being shown
        repeat (FRAME) begin
            if (!((n / SLOT) % DIGITS == 2 && (n % SLOT) == 5)) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (FRAME + 8) tick();

        repeat (1200) begin
            in_val   = 16'($urandom);
            in_dot   = 4'($urandom);
            in_blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 3) == 0) in_val = in_val & 16'h00FF;
            load     = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) lzb_en = ~lzb_en;
            rst      = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; load = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
